// File: rtl/snake_head_stepper_if.sv
// Control/status bundle between the game core and the head stepper.
// master drives start/pause/direction requests; slave returns head position and status.
interface snake_head_stepper_if #(
    parameter int unsigned XB = 5,
    parameter int unsigned YB = 5
);
    logic          start;
    logic          pause;
    logic          dir_valid;
    logic [1:0]    dir_req;
    logic [XB-1:0] head_x;
    logic [YB-1:0] head_y;
    logic [1:0]    cur_dir;
    logic          move_stb;
    logic          running;
    logic          game_over;

    modport master (
        output start, pause, dir_valid, dir_req,
        input  head_x, head_y, cur_dir, move_stb, running, game_over
    );

    modport slave (
        input  start, pause, dir_valid, dir_req,
        output head_x, head_y, cur_dir, move_stb, running, game_over
    );
endinterface

// File: rtl/snake_head_stepper.sv
// Synchronises the divided game clock into move ticks and steps the snake head.
// Optional macro SNAKE_WALL_KILL_EN: crossing a grid edge ends the game instead of wrapping.
module snake_head_stepper #(
    parameter int unsigned GRID_W  = 32,
    parameter int unsigned GRID_H  = 24,
    parameter int unsigned START_X = 16,
    parameter int unsigned START_Y = 12
) (
    input  logic                 clk65MHz,
    input  logic                 rst_n,
    input  logic                 clk_div,
    snake_head_stepper_if.slave  bus
);
    localparam int unsigned XB = $clog2(GRID_W - 1);
    localparam int unsigned YB = $clog2(GRID_H - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER} state_t;

    state_t          r_state;
    logic            r_s1, r_s2, r_p;
    logic [XB-1:0]   r_head_x;
    logic [YB-1:0]   r_head_y;
    logic [1:0]      r_cur_dir;
    logic [1:0]      r_pend_dir;
    logic            r_move_stb;
    logic            r_running;
    logic            r_game_over;

    logic            w_tick;
    logic            w_move_req;
    logic            w_move;
    logic            w_kill;
    logic            w_cross;
    logic [XB-1:0]   w_nx;
    logic [YB-1:0]   w_ny;
    logic [1:0]      w_ref;
    logic            w_dir_ok;

    assign w_tick     = r_s2 & ~r_p;
    // pause has priority over a coincident tick
    assign w_move_req = (r_state == ST_RUN) & w_tick & ~bus.pause;

    // Next head cell with wrap; w_cross flags an edge crossing
    always_comb begin
        w_nx    = r_head_x;
        w_ny    = r_head_y;
        w_cross = 1'b0;
        case (r_pend_dir)
            2'b00: begin
                w_cross = (r_head_y == '0);
                w_ny    = w_cross ? YB'(GRID_H - 1) : r_head_y - YB'(1);
            end
            2'b01: begin
                w_cross = (r_head_x == XB'(GRID_W - 1));
                w_nx    = w_cross ? '0 : r_head_x + XB'(1);
            end
            2'b10: begin
                w_cross = (r_head_y == YB'(GRID_H - 1));
                w_ny    = w_cross ? '0 : r_head_y + YB'(1);
            end
            default: begin
                w_cross = (r_head_x == '0);
                w_nx    = w_cross ? XB'(GRID_W - 1) : r_head_x - XB'(1);
            end
        endcase
    end

`ifdef SNAKE_WALL_KILL_EN
    assign w_move = w_move_req & ~w_cross;
    assign w_kill = w_move_req &  w_cross;
`else
    assign w_move = w_move_req;
    assign w_kill = 1'b0;
`endif

    // A request in a move cycle is judged against the direction being committed
    assign w_ref    = w_move ? r_pend_dir : r_cur_dir;
    assign w_dir_ok = bus.dir_valid & (r_state != ST_OVER) & (bus.dir_req != (w_ref ^ 2'b10));

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_p         <= 1'b0;
            r_head_x    <= XB'(START_X);
            r_head_y    <= YB'(START_Y);
            r_cur_dir   <= 2'b01;
            r_pend_dir  <= 2'b01;
            r_move_stb  <= 1'b0;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_s1       <= clk_div;
            r_s2       <= r_s1;
            r_p        <= r_s2;
            r_move_stb <= 1'b0;
            if (w_dir_ok) r_pend_dir <= bus.dir_req;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_move) begin
                        r_head_x   <= w_nx;
                        r_head_y   <= w_ny;
                        r_cur_dir  <= r_pend_dir;
                        r_move_stb <= 1'b1;
                    end else if (w_kill) begin
                        r_state     <= ST_OVER;
                        r_running   <= 1'b0;
                        r_game_over <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        r_state     <= ST_RUN;
                        r_running   <= 1'b1;
                        r_head_x    <= XB'(START_X);
                        r_head_y    <= YB'(START_Y);
                        r_cur_dir   <= 2'b01;
                        r_pend_dir  <= 2'b01;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.head_x   = r_head_x;
    assign bus.head_y   = r_head_y;
    assign bus.cur_dir  = r_cur_dir;
    assign bus.move_stb = r_move_stb;
    assign bus.running  = r_running;
`ifdef SNAKE_WALL_KILL_EN
    assign bus.game_over = r_game_over;
`else
    assign bus.game_over = 1'b0;
`endif
endmodule

// File: tb/tb_snake_head_stepper.sv
// Scoreboard bench for snake_head_stepper: expected moves are queued by the stimulus
// and checked by a monitor on every move_stb; status is checked directly.
module tb_snake_head_stepper;
    logic clk = 1'b0;
    logic rst_n;
    logic clk_div;

    snake_head_stepper_if #(.XB(5), .YB(5)) bus ();

    snake_head_stepper dut (
        .clk65MHz (clk),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] d;
    } mv_t;

    mv_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  m_x, m_y, m_dir, m_pend;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full clk_div period: enough high time for the move to land, then low
    task automatic div_tick();
        clk_div = 1'b1;
        repeat (4) step();
        clk_div = 1'b0;
        repeat (4) step();
    endtask

    task automatic push_move();
        case (m_pend)
            0:       m_y = (m_y == 0)  ? 23 : m_y - 1;
            1:       m_x = (m_x == 31) ? 0  : m_x + 1;
            2:       m_y = (m_y == 23) ? 0  : m_y + 1;
            default: m_x = (m_x == 0)  ? 31 : m_x - 1;
        endcase
        m_dir = m_pend;
        q.push_back('{x: 5'(m_x), y: 5'(m_y), d: 2'(m_dir)});
    endtask

    task automatic dir_pulse(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir_req   = d;
        step();
        bus.dir_valid = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.move_stb) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL move_unexpected: got=(%0d,%0d,%0d) want=none",
                         bus.head_x, bus.head_y, bus.cur_dir);
            end else begin
                mv_t e;
                e = q.pop_front();
                if (bus.head_x != e.x || bus.head_y != e.y || bus.cur_dir != e.d) begin
                    bad++;
                    $display("FAIL move: got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                             bus.head_x, bus.head_y, bus.cur_dir, e.x, e.y, e.d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clk_div = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir_req = 2'b00;
        m_x = 16; m_y = 12; m_dir = 1; m_pend = 1;
        repeat (2) step();
        chk("rst_head_x", bus.head_x, 16);
        chk("rst_head_y", bus.head_y, 12);
        chk("rst_cur_dir", bus.cur_dir, 1);
        chk("rst_move_stb", bus.move_stb, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_game_over", bus.game_over, 0);
        rst_n = 1'b1;
        step();

        // Ticks in IDLE must not move the head
        div_tick();
        chk("idle_head_x", bus.head_x, 16);

        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("start_running", bus.running, 1);

        // Latency: clk_div first sampled at edge N, move at N+2
        push_move();
        clk_div = 1'b1;
        step();
        chk("lat_stb_n", bus.move_stb, 0);
        step();
        chk("lat_stb_n1", bus.move_stb, 0);
        step();
        chk("lat_stb_n2", bus.move_stb, 1);
        chk("lat_head_x", bus.head_x, 17);
        chk("lat_head_y", bus.head_y, 12);
        step();
        chk("lat_single_pulse", bus.move_stb, 0);
        repeat (2) step();
        clk_div = 1'b0;
        repeat (4) step();

        // Reversal of committed right is dropped
        dir_pulse(2'b11);
        push_move();
        div_tick();
        chk("rev_cur_dir", bus.cur_dir, 1);
        chk("rev_head_x", bus.head_x, 18);

        // Up accepted, then left rejected as reversal of committed right
        dir_pulse(2'b00);
        dir_pulse(2'b11);
        m_pend = 0;
        push_move();
        div_tick();
        chk("buf_head_y", bus.head_y, 11);
        chk("buf_cur_dir", bus.cur_dir, 0);

        // Head right to the east edge
        dir_pulse(2'b01);
        m_pend = 1;
        for (int i = 0; i < 13; i++) begin
            push_move();
            div_tick();
        end
        chk("edge_head_x", bus.head_x, 31);
`ifdef SNAKE_WALL_KILL_EN
        div_tick();
        chk("kill_game_over", bus.game_over, 1);
        chk("kill_head_x", bus.head_x, 31);
        chk("kill_running", bus.running, 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("restart_head_x", bus.head_x, 16);
        chk("restart_head_y", bus.head_y, 12);
        chk("restart_running", bus.running, 1);
        chk("restart_game_over", bus.game_over, 0);
        m_x = 16; m_y = 12; m_dir = 1; m_pend = 1;
`else
        push_move();
        div_tick();
        chk("wrap_head_x", bus.head_x, 0);
        chk("wrap_game_over", bus.game_over, 0);
        // North edge wrap: y 11 -> 0 -> 23
        dir_pulse(2'b00);
        m_pend = 0;
        for (int i = 0; i < 12; i++) begin
            push_move();
            div_tick();
        end
        chk("wrap_head_y", bus.head_y, 23);
`endif

        // Pause coincident with the tick cycle suppresses the move
        clk_div = 1'b1;
        step();
        step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        chk("pause_running", bus.running, 0);
        chk("pause_move_stb", bus.move_stb, 0);
        repeat (3) step();
        clk_div = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) div_tick();
        chk("paused_head_x", bus.head_x, m_x);
        chk("paused_head_y", bus.head_y, m_y);
        bus.pause = 1'b1; step(); bus.pause = 1'b0;
        chk("resume_running", bus.running, 1);
        push_move();
        div_tick();
        chk("resume_head_x", bus.head_x, m_x);
        chk("resume_head_y", bus.head_y, m_y);

        // Asynchronous reset with a tick in flight
        clk_div = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_head_x", bus.head_x, 16);
        chk("arst_head_y", bus.head_y, 12);
        chk("arst_running", bus.running, 0);
        chk("arst_move_stb", bus.move_stb, 0);
        chk("arst_cur_dir", bus.cur_dir, 1);
        clk_div = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_head_x", bus.head_x, 16);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
